tema3_2a: RTL and testbench

TEMA3_2A -- requirements
Module: tema3_2a

---
 rtl/tema3_2a_pkg.sv | 17 +
 rtl/tema3_2a_sync_debounce.sv | 74 +++++++
 rtl/tema3_2a.sv | 41 ++++
 tb/tb_tema3_2a.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/tema3_2a_pkg.sv
// Shared widths, default debounce length and the select-to-one-hot decode
// for the tema3_2a switch-to-LED decoder.
package tema3_2a_pkg;

    localparam int unsigned SW_W                = 2;
    localparam int unsigned LED_W               = 4;
    localparam int unsigned DEBOUNCE_CYCLES_DEF = 4;

    // Map a select code to a one-hot LED vector (bit n set for select n).
    function automatic logic [LED_W-1:0] sel_to_onehot(input logic [SW_W-1:0] sel);
        logic [LED_W-1:0] oh;
        oh      = '0;
        oh[sel] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/tema3_2a_sync_debounce.sv
// Two-flop synchronizer plus whole-vector debounce filter for the switch pair.
// Build option: define TEMA3_2A_DEBOUNCE_EN to compile in the debounce
// filter; without it the filtered vector is the synchronized vector.
module tema3_2a_sync_debounce
    import tema3_2a_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
)(
    input  logic            clk,
    input  logic            rst_n,
    input  logic [SW_W-1:0] sw,
    output logic [SW_W-1:0] filt
);

    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 65535) begin : g_bad_debounce
        $error("tema3_2a_sync_debounce: DEBOUNCE_CYCLES must be 1..65535");
    end

    logic [SW_W-1:0] meta;
    logic [SW_W-1:0] sync;

    // Two-flop synchronizer, both bits moved together as one vector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            sync <= '0;
        end else begin
            meta <= sw;
            sync <= meta;
        end
    end

`ifdef TEMA3_2A_DEBOUNCE_EN
    localparam int unsigned         CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [SW_W-1:0]  filt_q;
    logic [SW_W-1:0]  filt_nxt;

    // Count only while sync differs from filt and is stable; meta != sync
    // flags that sync is about to change, which restarts the count. The
    // load happens on the count that would reach DEBOUNCE_CYCLES, so the
    // counter never exceeds DEBOUNCE_CYCLES-1 and cannot wrap.
    always_comb begin
        cnt_nxt  = '0;
        filt_nxt = filt_q;
        if (sync != filt_q && meta == sync) begin
            if (cnt >= CNT_LAST) begin
                filt_nxt = sync;
            end else begin
                cnt_nxt = cnt + 1'b1;
            end
        end
    end

    // Debounce counter and filtered vector registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            filt_q <= '0;
        end else begin
            cnt    <= cnt_nxt;
            filt_q <= filt_nxt;
        end
    end

    assign filt = filt_q;
`else
    assign filt = sync;
`endif

endmodule

// File: rtl/tema3_2a.sv
// Registered 2-to-4 one-hot decoder of a synchronized, debounced switch pair.
// Build option: TEMA3_2A_DEBOUNCE_EN enables the debounce filter.
module tema3_2a
    import tema3_2a_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
)(
    input  logic clk,
    input  logic rst_n,
    input  logic sw0,
    input  logic sw1,
    output logic led0,
    output logic led1,
    output logic led2,
    output logic led3
);

    logic [SW_W-1:0]  filt;
    logic [LED_W-1:0] led_q;

    tema3_2a_sync_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_sync_debounce (
        .clk   (clk),
        .rst_n (rst_n),
        .sw    ({sw1, sw0}),
        .filt  (filt)
    );

    // LED register reloaded every clock with the decode of the filtered select.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led_q <= '0;
        end else begin
            led_q <= sel_to_onehot(filt);
        end
    end

    assign {led3, led2, led1, led0} = led_q;

endmodule

// File: tb/tb_tema3_2a.sv
// Self-checking bench for tema3_2a: directed steps plus randomized switch
// activity compared against a sample-history reference model.
module tb_tema3_2a;

    localparam int unsigned D = 4;
`ifdef TEMA3_2A_DEBOUNCE_EN
    localparam int unsigned LAT = D + 2;
    localparam bit          DEB = 1'b1;
`else
    localparam int unsigned LAT = 2;
    localparam bit          DEB = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic sw0   = 1'b0;
    logic sw1   = 1'b0;
    logic led0, led1, led2, led3;
    logic [3:0] leds;

    int passed = 0;
    int total  = 0;

    tema3_2a #(.DEBOUNCE_CYCLES(D)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sw0   (sw0),
        .sw1   (sw1),
        .led0  (led0),
        .led1  (led1),
        .led2  (led2),
        .led3  (led3)
    );

    always #5 clk = ~clk;

    assign leds = {led3, led2, led1, led0};

    // Reference model: history of switch values seen at each rising edge.
    // The synchronized value after edge n is the switch sampled at edge n-1;
    // with debounce, a value is accepted once D+1 consecutive synchronized
    // samples agree on it. LEDs show the accepted value one edge later.
    logic [1:0] mq[$];
    logic [1:0] mfilt;
    logic [1:0] mv;
    logic [3:0] mled;
    bit         msame;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mfilt = 2'b00;
            mled  = 4'b0000;
            mq.delete();
            repeat (D + 2) mq.push_back(2'b00);
        end else begin
            mled = 4'b0001 << mfilt;
            mq.push_back({sw1, sw0});
            mv = mq[mq.size() - 2];
            if (DEB) begin
                msame = 1'b1;
                for (int i = 2; i <= int'(D) + 2; i++)
                    if (mq[mq.size() - i] != mv) msame = 1'b0;
                if (msame) mfilt = mv;
            end else begin
                mfilt = mv;
            end
            if (mq.size() > 64) void'(mq.pop_front());
        end
    end

    // One-hot watch: armed by any rising edge taken out of reset.
    bit armed = 1'b0;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) armed = 1'b0;
        else        armed = 1'b1;
    end

    always @(negedge clk) begin
        if (armed && rst_n) begin
            total++;
            assert ($onehot(leds)) passed++;
            else $error("FAIL onehot observed=%b expected=one-hot", leds);
        end
    end

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    endtask

    // Advance one clock and compare against the reference model.
    task automatic tick();
        @(negedge clk);
        check("model", leds, mled);
    endtask

    task automatic set_sw(input logic [1:0] v);
        {sw1, sw0} = v;
    endtask

    logic [1:0] prev;
    logic [1:0] rv;
    int unsigned hold;

    initial begin
        // Reset held with switches at 11.
        set_sw(2'b11);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_hold", leds, 4'b0000);

        // Release with switches at 00: first edge lights led0.
        set_sw(2'b00);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("first_edge", leds, 4'b0001);
        check("first_edge_model", leds, mled);
        repeat (10) tick();

`ifdef TEMA3_2A_DEBOUNCE_EN
        // Short pulse on sw0 must be filtered out.
        set_sw(2'b01);
        repeat (2) tick();
        set_sw(2'b00);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("glitch", leds, 4'b0001);
        end
`else
        set_sw(2'b01);
        repeat (2) tick();
        set_sw(2'b00);
        repeat (12) tick();
`endif

        // Sweep all selects with exact latency.
        prev = 2'b00;
        for (int v = 0; v < 4; v++) begin
            set_sw(2'(v));
            for (int i = 1; i <= 20; i++) begin
                @(negedge clk);
                check("sweep", leds, (i > int'(LAT)) ? (4'b0001 << v) : (4'b0001 << prev));
                check("sweep_model", leds, mled);
            end
            prev = 2'(v);
        end

        // Both bits flip together 01 -> 10: no intermediate code.
        set_sw(2'b01);
        repeat (20) tick();
        set_sw(2'b10);
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            check("atomic", leds, (i > int'(LAT)) ? 4'b0100 : 4'b0010);
        end

        // Reset mid-change 00 -> 11 abandons the pending change.
        set_sw(2'b00);
        repeat (20) tick();
        set_sw(2'b11);
        repeat (3) tick();
        #2 rst_n = 1'b0;
        #1 check("reset_async", leds, 4'b0000);
        repeat (3) begin
            @(negedge clk);
            check("reset_mid", leds, 4'b0000);
        end
        #1 rst_n = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            check("after_reset", leds, (i > int'(LAT)) ? 4'b1000 : 4'b0001);
            check("after_reset_model", leds, mled);
        end

        // Randomized switch activity with varied hold times.
        for (int n = 0; n < 60; n++) begin
            rv   = 2'($urandom_range(3));
            hold = $urandom_range(1, D + 3);
            set_sw(rv);
            repeat (hold) tick();
        end
        repeat (LAT + 2) tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    // Hard stop so the run cannot hang.
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
